// File: rtl/pad_mux_pkg.sv
// Shared types and constants for the pad function multiplexer.
package pad_mux_pkg;

    typedef enum logic [1:0] {
        FuncAltA    = 2'd0,
        FuncAltB    = 2'd1,
        FuncGpioIn  = 2'd2,
        FuncGpioOut = 2'd3
    } pad_func_e;

    typedef enum logic {
        StActive = 1'b0,
        StDrain  = 1'b1
    } pin_state_e;

    localparam logic [1:0] CFG_ADDR_FUNC     = 2'd0;
    localparam logic [1:0] CFG_ADDR_GPIO_OUT = 2'd1;
    localparam logic [1:0] CFG_ADDR_GPIO_IN  = 2'd2;
    localparam logic [1:0] CFG_ADDR_STATUS   = 2'd3;

    localparam int unsigned STATUS_LOCK_BIT = 31;
    localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/pad_mux_pin.sv
// One pad's function FSM: holds the applied function, runs the output dead-time
// drain after a target change, and muxes pad drive / peripheral input for that pin.
module pad_mux_pin
    import pad_mux_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 2,
    parameter pad_func_e   RST_FUNC    = FuncAltA
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_load,
    input  pad_func_e i_target,
    input  logic      i_gpio_out,
    input  logic      i_a_o,
    input  logic      i_a_oe,
    input  logic      i_b_o,
    input  logic      i_b_oe,
    input  logic      i_pad_o,
    output logic      o_pad_i,
    output logic      o_pad_oe,
    output logic      o_a_in,
    output logic      o_b_in,
    output logic      o_busy
);

    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES);

    pin_state_e       r_state;
    pin_state_e       w_state_nxt;
    pad_func_e        r_applied;
    pad_func_e        w_applied_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StActive;
            r_applied <= RST_FUNC;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_applied <= w_applied_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // A new target always restarts the full dead-time, even mid-drain.
    always_comb begin
        w_state_nxt   = r_state;
        w_applied_nxt = r_applied;
        w_cnt_nxt     = r_cnt;
        if (i_load) begin
            w_state_nxt = StDrain;
            w_cnt_nxt   = DEAD_LOAD;
        end else if (r_state == StDrain) begin
            if (r_cnt == '0) begin
                w_state_nxt   = StActive;
                w_applied_nxt = i_target;
            end else begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end
        end
    end

    assign w_busy = (r_state == StDrain);
    assign o_busy = w_busy;

    always_comb begin
        o_pad_i  = 1'b0;
        o_pad_oe = 1'b0;
        if (!w_busy) begin
            unique case (r_applied)
                FuncAltA: begin
                    o_pad_i  = i_a_o;
                    o_pad_oe = i_a_oe;
                end
                FuncAltB: begin
                    o_pad_i  = i_b_o;
                    o_pad_oe = i_b_oe;
                end
                FuncGpioIn: begin
                    o_pad_i  = 1'b0;
                    o_pad_oe = 1'b0;
                end
                FuncGpioOut: begin
                    o_pad_i  = i_gpio_out;
                    o_pad_oe = 1'b1;
                end
            endcase
        end
    end

    assign o_a_in = !w_busy && (r_applied == FuncAltA) && i_pad_o;
    assign o_b_in = !w_busy && (r_applied == FuncAltB) && i_pad_o;

endmodule

// File: rtl/pad_mux_ctrl.sv
// Pad function selector with config registers, GPIO synchronizer and per-pin dead-time.
// Define PAD_MUX_LOCK_EN to add a sticky STATUS[31] lock that blocks FUNC writes.
module pad_mux_ctrl
    import pad_mux_pkg::*;
#(
    parameter int unsigned            NPINS       = 8,
    parameter int unsigned            DEAD_CYCLES = 2,
    parameter logic [2*NPINS-1:0]     FUNC_RST    = (2*NPINS)'(16'hAA30)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic             cfg_re,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    input  logic [NPINS-1:0] periph_a_o,
    input  logic [NPINS-1:0] periph_a_oe,
    input  logic [NPINS-1:0] periph_b_o,
    input  logic [NPINS-1:0] periph_b_oe,
    output logic [NPINS-1:0] periph_a_in,
    output logic [NPINS-1:0] periph_b_in,
    output logic [NPINS-1:0] gpio_in,
    output logic [NPINS-1:0] pad_i,
    output logic [NPINS-1:0] pad_oe,
    input  logic [NPINS-1:0] pad_o
);

    localparam int unsigned FW = 2 * NPINS;

    logic [FW-1:0]    r_func;
    logic [NPINS-1:0] r_gpio_out;
    logic [NPINS-1:0] r_sync1;
    logic [NPINS-1:0] r_sync2;
    logic [31:0]      r_rdata;

    logic             w_lock;
    logic             w_func_we;
    logic             w_gpo_we;
    logic [NPINS-1:0] w_load;
    logic [NPINS-1:0] w_busy;
    logic [31:0]      w_status;
    logic [31:0]      w_rd_mux;
    logic             w_unused_wdata;

`ifdef PAD_MUX_LOCK_EN
    logic r_lock;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock <= 1'b0;
        end else if (cfg_we && (cfg_addr == CFG_ADDR_STATUS) && cfg_wdata[STATUS_LOCK_BIT]) begin
            r_lock <= 1'b1;
        end
    end

    assign w_lock = r_lock;
`else
    assign w_lock = 1'b0;
`endif

    assign w_func_we = cfg_we && (cfg_addr == CFG_ADDR_FUNC) && !w_lock;
    assign w_gpo_we  = cfg_we && (cfg_addr == CFG_ADDR_GPIO_OUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_func     <= FUNC_RST;
            r_gpio_out <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_func_we) begin
                r_func <= cfg_wdata[FW-1:0];
            end
            if (w_gpo_we) begin
                r_gpio_out <= cfg_wdata[NPINS-1:0];
            end
            r_sync1 <= pad_o;
            r_sync2 <= r_sync1;
            if (cfg_re) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    // Read mux sees pre-write state, so a same-cycle write is not visible.
    always_comb begin
        w_status                  = '0;
        w_status[NPINS-1:0]       = w_busy;
        w_status[STATUS_LOCK_BIT] = w_lock;
        case (cfg_addr)
            CFG_ADDR_FUNC:     w_rd_mux = 32'(r_func);
            CFG_ADDR_GPIO_OUT: w_rd_mux = 32'(r_gpio_out);
            CFG_ADDR_GPIO_IN:  w_rd_mux = 32'(r_sync2);
            default:           w_rd_mux = w_status;
        endcase
    end

    assign cfg_rdata      = r_rdata;
    assign gpio_in        = r_sync2;
    assign w_unused_wdata = ^cfg_wdata;

    for (genvar k = 0; k < NPINS; k++) begin : g_pin
        // Only a field that actually changes restarts that pin's dead-time.
        assign w_load[k] = w_func_we && (cfg_wdata[2*k+:2] != r_func[2*k+:2]);

        pad_mux_pin #(
            .DEAD_CYCLES (DEAD_CYCLES),
            .RST_FUNC    (pad_func_e'(FUNC_RST[2*k+:2]))
        ) u_pin (
            .clk        (clk),
            .rst        (rst),
            .i_load     (w_load[k]),
            .i_target   (pad_func_e'(r_func[2*k+:2])),
            .i_gpio_out (r_gpio_out[k]),
            .i_a_o      (periph_a_o[k]),
            .i_a_oe     (periph_a_oe[k]),
            .i_b_o      (periph_b_o[k]),
            .i_b_oe     (periph_b_oe[k]),
            .i_pad_o    (pad_o[k]),
            .o_pad_i    (pad_i[k]),
            .o_pad_oe   (pad_oe[k]),
            .o_a_in     (periph_a_in[k]),
            .o_b_in     (periph_b_in[k]),
            .o_busy     (w_busy[k])
        );
    end

endmodule
